// File: rtl/weight_fetch_streamer_if.sv
// Bus bundles for the weight fetch streamer: SRAM controller read port and
// the outgoing valid/ready weight stream toward the PE array.
interface wfs_sram_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] addr;
   logic              r_en;
   logic [DATA_W-1:0] r_d;
   logic              d_ready;

   modport master (output addr, r_en, input  r_d, d_ready);
   modport slave  (input  addr, r_en, output r_d, d_ready);
endinterface

interface wfs_stream_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, valid, input  ready);
   modport slave  (input  data, valid, output ready);
endinterface

// File: rtl/weight_fetch_streamer.sv
// Read-side DMA stage: issues sequential single-word SRAM reads under FIFO
// credit and streams the returned weights to the PE array.
module weight_fetch_streamer #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_WORDS  = 51200
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [15:0]       num_words_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   wfs_sram_if.master        sram_bus,
   wfs_stream_if.master      out_bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W:0] MAX_END = (ADDR_W+1)'(MAX_WORDS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [15:0]       remaining_q, remaining_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              push, pop, issue;
   logic [ADDR_W-1:0] issue_addr;
   logic [ADDR_W:0]   end_addr;

   assign end_addr = {1'b0, base_addr_i} + {{(ADDR_W-15){1'b0}}, num_words_i};

   // Only WAIT has a read in flight, so d_ready anywhere else is dropped.
   assign push    = (state_q == S_WAIT) && sram_bus.d_ready;
   assign pop     = (count_q != '0) && out_bus.ready;
   assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      issue       = 1'b0;
      issue_addr  = cur_addr_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (end_addr > MAX_END) begin
                  err_d = 1'b1;
               end else if (num_words_i == 16'd0) begin
                  done_d = 1'b1;
               end else begin
                  cur_addr_d  = base_addr_i;
                  remaining_d = num_words_i;
                  busy_d      = 1'b1;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (count_q < CNT_W'(FIFO_DEPTH)) begin
               issue   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (sram_bus.d_ready) begin
               cur_addr_d  = cur_addr_q + ADDR_W'(1);
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  state_d = S_DRAIN;
               end else if (count_q < CNT_W'(FIFO_DEPTH - 1)) begin
                  // Room remains even after this cycle's push: re-issue at once.
                  issue      = 1'b1;
                  issue_addr = cur_addr_q + ADDR_W'(1);
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            if (count_d == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         // NOTE: storage is cleared so the head reads zero after reset.
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         count_q     <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= sram_bus.r_d;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   assign sram_bus.r_en = issue;
   assign sram_bus.addr = issue_addr;
   assign out_bus.data  = mem_q[rd_ptr_q];
   assign out_bus.valid = (count_q != '0);
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_weight_fetch_streamer.sv
// Self-checking bench for weight_fetch_streamer: SRAM latency model, stream
// monitor and an address-list reference for each command.
`timescale 1ns/1ps
module tb_weight_fetch_streamer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 8;
   localparam int MAXW   = 51200;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] base_addr_i = '0;
   logic [15:0] num_words_i = '0;
   logic        busy_o, done_o, err_o;

   wfs_sram_if   #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram ();
   wfs_stream_if #(.DATA_W(DATA_W))                  strm ();

   weight_fetch_streamer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .MAX_WORDS(MAXW)
   ) dut (
      .clock(clock), .reset(reset), .start_i(start_i),
      .base_addr_i(base_addr_i), .num_words_i(num_words_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .sram_bus(sram), .out_bus(strm)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clock) cyc++;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
   endfunction

   // SRAM controller: a read seen in cycle k answers with d_ready in cycle k+2.
   logic        en_s1 = 1'b0, en_s2 = 1'b0;
   logic [31:0] a_s1 = '0, a_s2 = '0;
   always @(negedge clock) begin
      en_s2 = en_s1; a_s2 = a_s1;
      en_s1 = sram.r_en; a_s1 = sram.addr;
   end
   always @(posedge clock) begin
      #1;
      sram.d_ready = en_s2;
      sram.r_d     = en_s2 ? mem_word(a_s2) : 32'hDEAD_BEEF;
   end

   // Monitor
   logic [31:0] iss_addr[$];
   int          iss_cyc[$];
   logic [31:0] pop_data[$];
   int          pop_cyc[$];
   int done_n, done_cyc, err_n, err_cyc, occ_max;
   bit busy_seen, busy_at_done;

   always @(negedge clock) begin
      if (reset) begin
         if (sram.r_en) begin
            iss_addr.push_back(sram.addr);
            iss_cyc.push_back(cyc);
         end
         if (iss_addr.size() - pop_data.size() > occ_max)
            occ_max = iss_addr.size() - pop_data.size();
         if (strm.valid && strm.ready) begin
            pop_data.push_back(strm.data);
            pop_cyc.push_back(cyc);
         end
         if (done_o) begin done_n++; done_cyc = cyc; busy_at_done = busy_o; end
         if (err_o)  begin err_n++;  err_cyc  = cyc; end
         if (busy_o) busy_seen = 1'b1;
      end
   end

   task automatic clear_mon();
      iss_addr.delete(); iss_cyc.delete(); pop_data.delete(); pop_cyc.delete();
      done_n = 0; done_cyc = -1; err_n = 0; err_cyc = -1; occ_max = 0;
      busy_seen = 1'b0; busy_at_done = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] base, input logic [15:0] num, output int s_cyc);
      @(posedge clock); #1;
      start_i = 1'b1; base_addr_i = base; num_words_i = num; s_cyc = cyc;
      @(posedge clock); #1;
      start_i = 1'b0; base_addr_i = $urandom; num_words_i = 16'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (done_n > 0) begin ok = 1'b1; break; end
      end
   endtask

   // Reference: a command fetches words base..base+num-1 and delivers them in order.
   task automatic compare_stream(input string tag, input logic [31:0] base, input int num);
      checks++;
      if (iss_addr.size() != num || pop_data.size() != num) begin
         errors++;
         $display("FAIL %s count: issued %0d popped %0d, required %0d", tag, iss_addr.size(), pop_data.size(), num);
      end else begin
         for (int i = 0; i < num; i++) begin
            checks++;
            if (iss_addr[i] !== base + 32'(i) || pop_data[i] !== mem_word(base + 32'(i))) begin
               errors++;
               $display("FAIL %s word %0d: addr %h data %h, required addr %h data %h", tag, i,
                        iss_addr[i], pop_data[i], base + 32'(i), mem_word(base + 32'(i)));
            end
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || sram.r_en !== 1'b0 ||
          sram.addr !== 32'h0 || strm.valid !== 1'b0 || strm.data !== 32'h0) begin
         errors++;
         $display("FAIL %s: busy %b done %b err %b r_en %b addr %h valid %b data %h, required all zero",
                  tag, busy_o, done_o, err_o, sram.r_en, sram.addr, strm.valid, strm.data);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; strm.ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle_outputs("reset_values");
      @(posedge clock); #1 reset = 1'b1;
   endtask

   task automatic test_bank_cross();
      int s; bit ok;
      clear_mon(); strm.ready = 1'b1;
      pulse_start(32'h7FE, 16'd4, s);
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bank_cross timeout: done not seen, required within 200 cycles"); end
      compare_stream("bank_cross", 32'h7FE, 4);
      if (iss_cyc.size() == 4 && pop_cyc.size() == 4) begin
         checks++;
         if (iss_cyc[0] != s + 1) begin
            errors++; $display("FAIL bank_cross first_issue: cycle %0d, required %0d", iss_cyc[0], s + 1);
         end
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (iss_cyc[i] - iss_cyc[i-1] != 2) begin
               errors++; $display("FAIL bank_cross spacing %0d: %0d cycles, required 2", i, iss_cyc[i] - iss_cyc[i-1]);
            end
         end
         checks++;
         if (done_cyc != pop_cyc[3] + 1 || busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL bank_cross done_timing: done at %0d busy %b, required %0d busy 0", done_cyc, busy_at_done, pop_cyc[3] + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      int s; bit ok; logic [31:0] base;
      clear_mon(); strm.ready = 1'b0;
      base = $urandom_range(0, MAXW - 12);
      pulse_start(base, 16'd12, s);
      repeat (60) @(negedge clock);
      checks++;
      if (iss_addr.size() != DEPTH || strm.valid !== 1'b1) begin
         errors++; $display("FAIL backpressure stall: issued %0d valid %b, required %0d valid 1", iss_addr.size(), strm.valid, DEPTH);
      end
      @(posedge clock); #1 strm.ready = 1'b1;
      wait_done(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL backpressure timeout: done not seen, required within 300 cycles"); end
      compare_stream("backpressure", base, 12);
   endtask

   task automatic test_zero_and_range();
      int s; bit ok;
      clear_mon(); strm.ready = 1'b1;
      pulse_start(32'h123, 16'd0, s);
      repeat (5) @(negedge clock);
      checks++;
      if (done_n != 1 || done_cyc != s + 1 || iss_addr.size() != 0 || busy_seen) begin
         errors++;
         $display("FAIL zero_words: done %0d at %0d issued %0d busy_seen %b, required 1 at %0d issued 0 busy_seen 0",
                  done_n, done_cyc, iss_addr.size(), busy_seen, s + 1);
      end
      clear_mon();
      pulse_start(32'd51198, 16'd3, s);
      repeat (8) @(negedge clock);
      checks++;
      if (err_n != 1 || err_cyc != s + 1 || iss_addr.size() != 0 || busy_seen || done_n != 0) begin
         errors++;
         $display("FAIL range_err: err %0d at %0d issued %0d busy_seen %b done %0d, required 1 at %0d issued 0 busy_seen 0 done 0",
                  err_n, err_cyc, iss_addr.size(), busy_seen, done_n, s + 1);
      end
      clear_mon();
      pulse_start(32'd51197, 16'd3, s);
      wait_done(100, ok);
      checks++;
      if (!ok || err_n != 0) begin
         errors++; $display("FAIL range_edge: done %b err %0d, required done 1 err 0", ok, err_n);
      end
      compare_stream("range_edge", 32'd51197, 3);
   endtask

   task automatic test_reset_mid();
      int s; bit ok; logic [31:0] base;
      clear_mon(); strm.ready = 1'b1;
      base = $urandom_range(0, MAXW - 10);
      pulse_start(base, 16'd10, s);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (iss_addr.size() == 5) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_mid reach: issued %0d, required 5", iss_addr.size()); end
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(negedge clock);
      check_idle_outputs("reset_mid_values");
      clear_mon();
      repeat (6) @(negedge clock);
      checks++;
      if (strm.valid !== 1'b0 || done_n != 0 || iss_addr.size() != 0) begin
         errors++;
         $display("FAIL reset_mid stale: valid %b done %0d issued %0d, required 0 0 0", strm.valid, done_n, iss_addr.size());
      end
      base = $urandom_range(0, MAXW - 2);
      pulse_start(base, 16'd2, s);
      wait_done(100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_mid restart timeout: done not seen, required within 100 cycles"); end
      compare_stream("reset_mid_restart", base, 2);
   endtask

   task automatic test_start_while_busy();
      int s, s2; bit ok; logic [31:0] base;
      clear_mon(); strm.ready = 1'b1;
      base = $urandom_range(0, MAXW - 6);
      pulse_start(base, 16'd6, s);
      repeat (3) @(posedge clock);
      pulse_start(32'd51199, 16'd3, s2);
      wait_done(200, ok);
      repeat (20) @(negedge clock);
      checks++;
      if (!ok || done_n != 1 || err_n != 0) begin
         errors++; $display("FAIL busy_start: done %0d err %0d, required done 1 err 0", done_n, err_n);
      end
      compare_stream("busy_start", base, 6);
   endtask

   task automatic test_random_ready();
      int s; bit ok; logic [31:0] base;
      clear_mon();
      base = $urandom_range(0, MAXW - 100);
      pulse_start(base, 16'd100, s);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clock); #1 strm.ready = 1'($urandom_range(0, 1));
         if (done_n > 0) begin ok = 1'b1; break; end
      end
      strm.ready = 1'b1;
      checks++;
      if (!ok) begin errors++; $display("FAIL random_ready timeout: done not seen, required within 3000 cycles"); end
      checks++;
      if (occ_max > DEPTH) begin
         errors++; $display("FAIL random_ready occupancy: peak %0d, required at most %0d", occ_max, DEPTH);
      end
      compare_stream("random_ready", base, 100);
   endtask

   initial begin
      test_reset();
      test_bank_cross();
      test_backpressure();
      test_zero_and_range();
      test_reset_mid();
      test_start_while_busy();
      test_random_ready();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/weight_fetch_streamer.md
Name: weight_fetch_streamer

Overview:
- Read-side DMA stage directly upstream of the PE array and downstream of the weight SRAM controller (25 banks x 2048 words x 32 bit; bank = addr[15:11], word = addr[10:0]).
- On a start command it issues sequential single-word reads to the controller over its addr/r_en/d_ready interface.
- Returned words are buffered in an internal FIFO and presented to the PE array on a valid/ready stream.
- Flow control is credit-based: a read is issued only if the FIFO is guaranteed room, so the FIFO never overflows.

Parameters:
DATA_W, 32, weight word width
ADDR_W, 32, controller address width
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)
MAX_WORDS, 51200, valid address space (25*2048)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_W  first word address
num_words  in  16  words to fetch
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
err  out  1  one-cycle pulse on rejected command
sram_addr  out  ADDR_W  to controller addr
sram_r_en  out  1  to controller r_en
sram_r_d  in  DATA_W  from controller r_d
sram_d_ready  in  1  from controller d_ready
out_data  out  DATA_W  FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accept

Behaviour:
- Synchronous active-low reset, applied on the clock edge while reset==0. Reset values: busy=0, done=0, err=0, sram_r_en=0, sram_addr=0, out_valid=0, out_data=0. FIFO is flushed and the state goes to IDLE.
- Reset asserted mid-operation aborts immediately. No done pulse. Any stale d_ready after reset is ignored.
- States:
  - IDLE: start=1 with base_addr+num_words > MAX_WORDS -> err=1 for one cycle, stay IDLE, no reads issued. start=1 with num_words==0 -> done=1 the next cycle, busy never set. Otherwise latch cur_addr=base_addr, remaining=num_words, busy=1, go to ISSUE.
  - ISSUE: if credit is available (fifo_count + outstanding < FIFO_DEPTH), drive sram_r_en=1 for exactly one cycle with sram_addr=cur_addr, set outstanding=1, go to WAIT. Without credit, hold in ISSUE with r_en=0.
  - WAIT: sram_addr is held stable and r_en=0. On sram_d_ready=1, push sram_r_d into the FIFO, outstanding=0, cur_addr+1, remaining-1. In that same cycle, if remaining-1>0 and credit is available, drive r_en=1 with the new address and stay in WAIT (back-to-back issue). If remaining-1>0 without credit, go to ISSUE. If remaining-1==0, go to DRAIN.
  - DRAIN: when the FIFO is empty, pulse done=1, clear busy, go to IDLE.
- Latency and throughput:
  - Read issued in cycle N; d_ready is visible in cycle N+2; data is written to the FIFO at the end of N+2.
  - Steady state is 1 word per 2 cycles.
  - Only one outstanding read at any time.
- FIFO:
  - out_data is the registered head; out_valid = !empty.
  - A pop occurs when out_valid && out_ready.
  - A simultaneous push and pop when full is legal; count is unchanged.
  - A push when full is impossible by construction.
- Addresses increment linearly across bank boundaries (0x7FF -> 0x800 selects the next bank). There is no wrap at MAX_WORDS because the range is checked at start.
- start while busy is ignored, with no err.
- sram_d_ready while not in WAIT is ignored.

Test Plan:
- base_addr=0x7FE, num_words=4, out_ready=1 -> sram_addr sequence 0x7FE, 0x7FF, 0x800, 0x801. r_en pulses exactly 2 cycles apart. out_data equals the SRAM contents in order. done pulses 1 cycle after the 4th pop; busy deasserts in the same cycle.
- num_words=12, out_ready=0 -> exactly 8 r_en pulses, then r_en stays 0. Raising out_ready -> the remaining 4 reads are issued and 12 words are delivered in order.
- num_words=0 -> no r_en, done=1 exactly one cycle after start. base_addr=51198, num_words=3 -> err=1 for one cycle, no r_en, busy stays 0.
- reset=0 held for 1 cycle during WAIT of word 5 of 10 -> all outputs return to reset values. A subsequent d_ready is ignored. A new start with 2 words completes normally.
- Second start pulse during busy with different base_addr -> ignored; the original stream completes unchanged.
- Random out_ready toggling over 100 words -> no data loss or duplication, FIFO count never exceeds 8.
